// File: rtl/data_bus_ctrl.sv
// Memory/IO stage behind the single-cycle CPU: decodes the address map into data RAM, LEDs,
// synchronised switches, a free-running timer and a byte TX FIFO with a valid/ready output.
module data_bus_ctrl #(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = FIFO_AW + 1;

  // Word addresses (byte address >> 2) of the IO registers.
  localparam logic [29:0] WA_LED = 30'h400;
  localparam logic [29:0] WA_SW  = 30'h401;
  localparam logic [29:0] WA_TMR = 30'h402;
  localparam logic [29:0] WA_TXD = 30'h403;
  localparam logic [29:0] WA_TXS = 30'h404;

  logic [31:0]         r_ram [RAM_WORDS];
  logic [15:0]         r_leds;
  logic [15:0]         r_sw_meta;
  logic [15:0]         r_sw_sync;
  logic [31:0]         r_timer;
  logic [7:0]          r_fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;

  logic [29:0]         w_wa;
  logic                w_unused;
  logic                w_ram_sel;
  logic [RAM_AW-1:0]   w_ram_idx;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_push_ok;
  logic                w_pop;
  logic [3:0]          w_cnt4;

  assign w_wa      = Addr[31:2];
  assign w_unused  = ^Addr[1:0];
  assign w_ram_sel = (Addr[31:RAM_AW+2] == '0);
  assign w_ram_idx = Addr[RAM_AW+1:2];

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = MemWrite && (w_wa == WA_TXD);
  assign w_pop     = tx_valid && tx_ready;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_cnt4    = 4'(r_count);

  assign leds      = r_leds;
  assign tx_valid  = !w_empty;
  assign tx_data   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_sel) begin
      r_ram[w_ram_idx] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo[r_wr_ptr] <= WriteData[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_leds    <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_timer   <= '0;
    end else begin
      r_sw_meta <= switches;
      r_sw_sync <= r_sw_meta;
      if (MemWrite && (w_wa == WA_LED)) begin
        r_leds <= WriteData[15:0];
      end
      if (MemWrite && (w_wa == WA_TMR)) begin
        r_timer <= WriteData;
      end else begin
        r_timer <= r_timer + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (MemWrite && (w_wa == WA_TXS)) begin
        r_overflow <= 1'b0;
      end else if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (w_ram_sel) begin
      ReadData = r_ram[w_ram_idx];
    end else begin
      case (w_wa)
        WA_LED:  ReadData = {16'h0000, r_leds};
        WA_SW:   ReadData = {16'h0000, r_sw_sync};
        WA_TMR:  ReadData = r_timer;
        WA_TXS:  ReadData = {24'h000000, w_cnt4, 1'b0, r_overflow, w_empty, w_full};
        default: ReadData = '0;
      endcase
    end
  end

endmodule
